// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle ALU with shift-add multiply; optional flag outputs under ALU_FLAGS_EN
module alu_mc #(
  parameter int WIDTH  = 16,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  source1,
  input  logic [WIDTH-1:0]  source2,
  input  logic [CTRL_W-1:0] ALU_CTRL,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  result,
`ifdef ALU_FLAGS_EN
  output logic              zero,
  output logic              carry,
  output logic              overflow,
`endif
  output logic              busy
);

  localparam logic [CTRL_W-1:0] OP_AND   = CTRL_W'(4'b0000);
  localparam logic [CTRL_W-1:0] OP_OR    = CTRL_W'(4'b0001);
  localparam logic [CTRL_W-1:0] OP_ADD   = CTRL_W'(4'b0010);
  localparam logic [CTRL_W-1:0] OP_XOR   = CTRL_W'(4'b0011);
  localparam logic [CTRL_W-1:0] OP_SLTU  = CTRL_W'(4'b0101);
  localparam logic [CTRL_W-1:0] OP_SUB   = CTRL_W'(4'b0110);
  localparam logic [CTRL_W-1:0] OP_SLT   = CTRL_W'(4'b0111);
  localparam logic [CTRL_W-1:0] OP_MUL   = CTRL_W'(4'b1000);
  localparam logic [CTRL_W-1:0] OP_MULHU = CTRL_W'(4'b1001);
  localparam logic [CTRL_W-1:0] OP_NOR   = CTRL_W'(4'b1100);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_HOLD} state_t;

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   acc, mcand, acc_step;
  logic [WIDTH-1:0]     mplier, alu_res;
  logic [CNT_W-1:0]     cnt;
  logic                 op_hi, is_mul, last_step;
  logic [WIDTH:0]       sum_ext, dif_ext;
`ifdef ALU_FLAGS_EN
  logic                 carry_d, overflow_d;
`endif

  assign is_mul    = (ALU_CTRL == OP_MUL) || (ALU_CTRL == OP_MULHU);
  assign last_step = (cnt == CNT_W'(WIDTH - 1));
  assign acc_step  = acc + (mplier[0] ? mcand : '0);
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_HOLD);
  assign busy      = (state_q == S_MUL);

  // Single-cycle ops; the extended sum/difference also supply carry and overflow
  always_comb begin
    sum_ext = {1'b0, source1} + {1'b0, source2};
    dif_ext = {1'b0, source1} + {1'b0, ~source2} + (WIDTH+1)'(1);
    alu_res = '0;
    case (ALU_CTRL)
      OP_AND:  alu_res = source1 & source2;
      OP_OR:   alu_res = source1 | source2;
      OP_ADD:  alu_res = sum_ext[WIDTH-1:0];
      OP_XOR:  alu_res = source1 ^ source2;
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (source1 < source2)};
      OP_SUB:  alu_res = dif_ext[WIDTH-1:0];
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(source1) < $signed(source2))};
      OP_NOR:  alu_res = ~(source1 | source2);
      default: alu_res = '0;
    endcase
`ifdef ALU_FLAGS_EN
    carry_d    = 1'b0;
    overflow_d = 1'b0;
    if (ALU_CTRL == OP_ADD) begin
      carry_d    = sum_ext[WIDTH];
      overflow_d = (source1[WIDTH-1] == source2[WIDTH-1]) &&
                   (sum_ext[WIDTH-1] != source1[WIDTH-1]);
    end else if (ALU_CTRL == OP_SUB) begin
      carry_d    = dif_ext[WIDTH];
      overflow_d = (source1[WIDTH-1] != source2[WIDTH-1]) &&
                   (dif_ext[WIDTH-1] != source1[WIDTH-1]);
    end
`endif
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; in_valid outside IDLE is simply not looked at
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (in_valid) state_d = is_mul ? S_MUL : S_HOLD;
      S_MUL:  if (last_step) state_d = S_HOLD;
      S_HOLD: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operand capture, shift-add iteration and result/flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      cnt      <= '0;
      op_hi    <= 1'b0;
      result   <= '0;
`ifdef ALU_FLAGS_EN
      zero     <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) begin
          if (is_mul) begin
            mcand  <= {{WIDTH{1'b0}}, source1};
            mplier <= source2;
            op_hi  <= (ALU_CTRL == OP_MULHU);
            acc    <= '0;
            cnt    <= '0;
          end else begin
            result   <= alu_res;
`ifdef ALU_FLAGS_EN
            zero     <= (alu_res == '0);
            carry    <= carry_d;
            overflow <= overflow_d;
`endif
          end
        end
        S_MUL: begin
          acc    <= acc_step;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
          if (last_step) begin
            result   <= op_hi ? acc_step[2*WIDTH-1:WIDTH] : acc_step[WIDTH-1:0];
`ifdef ALU_FLAGS_EN
            zero     <= op_hi ? (acc_step[2*WIDTH-1:WIDTH] == '0) : (acc_step[WIDTH-1:0] == '0);
            carry    <= 1'b0;
            overflow <= 1'b0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - directed self-checking bench for alu_mc (default build, WIDTH=16)
module tb_alu_mc;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  source1 = '0;
  logic [W-1:0]  source2 = '0;
  logic [3:0]    ALU_CTRL = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  result;
  logic          busy;

  int checks = 0;
  int errors = 0;

  alu_mc #(.WIDTH(W), .CTRL_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .source1(source1), .source2(source2), .ALU_CTRL(ALU_CTRL),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  // Present one op for exactly one edge, then scramble the inputs
  task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    ALU_CTRL = op; source1 = a; source2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    source1 = W'($urandom); source2 = W'($urandom); ALU_CTRL = 4'b0010;
  endtask

  task automatic wait_result(input string name, input int exp_lat, input logic [W-1:0] exp_res,
                             input int exp_busy);
    int lat = 1;
    int nb = 0;
    while (!out_valid && lat < 40) begin
      if (busy) nb++;
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL %s valid: got %b want 1", name, out_valid); end
    checks++; if (lat !== exp_lat) begin errors++; $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat); end
    checks++; if (result !== exp_res) begin errors++; $display("FAIL %s result: got %h want %h", name, result, exp_res); end
    checks++; if (nb !== exp_busy) begin errors++; $display("FAIL %s busy cycles: got %0d want %0d", name, nb, exp_busy); end
  endtask

  task automatic drain(input string name);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s drain valid: got %b want 0", name, out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL %s drain in_ready: got %b want 1", name, in_ready); end
  endtask

  task automatic run(input string name, input logic [3:0] op, input logic [W-1:0] a,
                     input logic [W-1:0] b, input int lat, input logic [W-1:0] r, input int nb);
    do_op(op, a, b);
    wait_result(name, lat, r, nb);
    drain(name);
  endtask

  task automatic test_reset();
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
    checks++; if (result !== 16'h0000) begin errors++; $display("FAIL reset result: got %h want 0000", result); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post-reset in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_reset_mid_mul();
    do_op(4'b1000, 16'h00FF, 16'h0003);
    repeat (4) begin @(posedge clk); #1; end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midmul busy before reset: got %b want 1", busy); end
    rst_n = 1'b0; #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midmul out_valid: got %b want 0", out_valid); end
    checks++; if (result !== 16'h0000) begin errors++; $display("FAIL midmul result: got %h want 0000", result); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midmul busy: got %b want 0", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midmul in_ready: got %b want 1", in_ready); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run("post-reset add", 4'b0010, 16'h0001, 16'h0001, 1, 16'h0002, 0);
  endtask

  task automatic test_single_cycle();
    run("add wrap", 4'b0010, 16'hFFFF, 16'h0001, 1, 16'h0000, 0);
    run("sub neg",  4'b0110, 16'h0005, 16'h0007, 1, 16'hFFFE, 0);
    run("and",      4'b0000, 16'hF0F0, 16'hFF00, 1, 16'hF000, 0);
    run("or",       4'b0001, 16'hF0F0, 16'h0F00, 1, 16'hFFF0, 0);
    run("xor",      4'b0011, 16'hAAAA, 16'hFFFF, 1, 16'h5555, 0);
    run("nor",      4'b1100, 16'h0F0F, 16'hF000, 1, 16'h00F0, 0);
  endtask

  task automatic test_compare();
    run("slt neg",  4'b0111, 16'h8000, 16'h0001, 1, 16'h0001, 0);
    run("sltu big", 4'b0101, 16'h8000, 16'h0001, 1, 16'h0000, 0);
    run("slt eq",   4'b0111, 16'h0003, 16'h0003, 1, 16'h0000, 0);
    run("sltu lt",  4'b0101, 16'h0001, 16'h8000, 1, 16'h0001, 0);
  endtask

  task automatic test_multiply();
    run("mul",      4'b1000, 16'h1234, 16'h0010, 17, 16'h2340, 16);
    run("mulhu",    4'b1001, 16'hFFFF, 16'hFFFF, 17, 16'hFFFE, 16);
    run("mul odd",  4'b1000, 16'h00FF, 16'h0003, 17, 16'h02FD, 16);
  endtask

  task automatic test_illegal();
    run("illegal f", 4'b1111, 16'hA5A5, 16'h5A5A, 1, 16'h0000, 0);
    run("illegal 4", 4'b0100, 16'h1234, 16'h4321, 1, 16'h0000, 0);
  endtask

  task automatic test_backpressure();
    do_op(4'b0010, 16'h0003, 16'h0004);
    wait_result("bp add", 1, 16'h0007, 0);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin ALU_CTRL = 4'b0000; source1 = 16'hFFFF; source2 = 16'h1111; in_valid = 1'b1; end
      if (i == 5) in_valid = 1'b0;
      @(posedge clk); #1;
      checks++; if (result !== 16'h0007) begin errors++; $display("FAIL bp result cycle %0d: got %h want 0007", i, result); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp in_ready cycle %0d: got %b want 0", i, in_ready); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp out_valid cycle %0d: got %b want 1", i, out_valid); end
    end
    drain("bp");
    repeat (2) @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp ignored op: out_valid got %b want 0", out_valid); end
    checks++; if (result !== 16'h0007) begin errors++; $display("FAIL bp stale result: got %h want 0007", result); end
  endtask

  task automatic test_back_to_back();
    run("b2b 1", 4'b0010, 16'h1000, 16'h0234, 1, 16'h1234, 0);
    run("b2b 2", 4'b1000, 16'h0003, 16'h0005, 17, 16'h000F, 16);
    run("b2b 3", 4'b0110, 16'h0000, 16'h0001, 1, 16'hFFFF, 0);
  endtask

  initial begin
    test_reset();
    test_reset_mid_mul();
    test_single_cycle();
    test_compare();
    test_multiply();
    test_illegal();
    test_backpressure();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
Parametrised multi-cycle ALU for the next-generation CPU datapath. It keeps the existing ALU_CTRL encodings for add, sub and slt, and adds logic, unsigned-compare and iterative shift-add multiply operations. Operands enter through a valid/ready handshake and results leave through a held valid/ready handshake. Sits between the ID/EX operand latch and the EX/MEM stage; the pipeline stalls while in_ready is low.

Parameters:
WIDTH, 16, operand/result width in bits (>=4)
CTRL_W, 4, ALU_CTRL width; fixed at 4 for this generation

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand/op presented
in_ready  output  1  block can accept an op
source1  input  WIDTH  operand A
source2  input  WIDTH  operand B
ALU_CTRL  input  CTRL_W  operation select
out_valid  output  1  result register valid
out_ready  input  1  consumer accepts result
result  output  WIDTH  registered result
busy  output  1  multiply iteration in progress

Behaviour:
- ALU_CTRL codes: 0000 AND; 0001 OR; 0010 ADD; 0011 XOR; 0101 SLTU (unsigned A<B -> 1 else 0); 0110 SUB; 0111 SLT (signed two's-complement A<B); 1000 MUL (low WIDTH bits of A*B); 1001 MULHU (high WIDTH bits of unsigned A*B); 1100 NOR. Any other code -> result 0, completes as a single-cycle op.
- Arithmetic modulo 2^WIDTH. Carry out is discarded unless ALU_FLAGS_EN is defined.
- FSM states: IDLE, MUL, HOLD.
  - IDLE: in_ready=1. On in_valid with a single-cycle op: compute, register result, go to HOLD. On in_valid with MUL/MULHU: latch A, B and op, clear the 2*WIDTH accumulator and the counter, go to MUL.
  - MUL: one shift-add step per cycle, LSB of multiplier first. After exactly WIDTH steps, load result with the low or high half per the latched op and go to HOLD. busy=1 only in this state.
  - HOLD: out_valid=1 and result stable. If out_ready=1, go to IDLE next cycle. in_ready=0 in this state, so an op cannot be accepted in the same cycle as result drain.
- Latency from the accept edge to out_valid: 1 cycle for single-cycle ops, WIDTH+1 cycles for MUL/MULHU.
- Minimum initiation interval is 2 cycles.
- Inputs are sampled only at the accept edge. Changes to source1, source2 or ALU_CTRL after that edge have no effect.
- in_valid while not in IDLE is ignored; it is not queued.
- out_ready while out_valid=0 is ignored.
- Reset (async assert, sync deassert by the system) from any state, including mid-MUL:
  - state returns to IDLE; result, accumulator and counter clear to 0.
  - out_valid=0, busy=0, in_ready=1 from the first edge after deassert.
  - the in-flight op is lost and no partial result is emitted.
- Simultaneous events: in_valid is high only at IDLE acceptance, so no collision with drain is possible.

Optional Feature:
ALU_FLAGS_EN — when defined, adds output ports zero (1), carry (1) and overflow (1), registered together with result and held while in HOLD.
- zero: result==0.
- carry: ADD carry-out; SUB no-borrow (A>=B unsigned).
- overflow: signed overflow for ADD/SUB.
- All flags are 0 for other ops and after reset.
When ALU_FLAGS_EN is undefined, these ports and their logic are absent and the port list is exactly as above.

Test Plan:
- Reset mid-MUL: WIDTH=16, MUL 0x00FF*0x0003, assert rst_n=0 at cycle 5 of MUL -> out_valid=0, result=0x0000, busy=0; after release, next ADD 1+1 gives 0x0002 with no stale product.
- Single-cycle ops: ADD 0xFFFF+0x0001 -> result 0x0000 one cycle after accept (flags build: zero=1, carry=1). SUB 0x0005-0x0007 -> 0xFFFE.
- Signed vs unsigned compare: SLT 0x8000 vs 0x0001 -> 0x0001; SLTU with the same operands -> 0x0000. SLT 0x0003 vs 0x0003 -> 0x0000.
- Multiply: MUL 0x1234*0x0010 -> 0x2340 with out_valid exactly 17 cycles after accept; MULHU 0xFFFF*0xFFFF -> 0xFFFE; busy high for exactly 16 cycles.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> result stable, in_ready=0, a new in_valid is ignored; raise out_ready -> IDLE next cycle, in_ready=1.
- Illegal code and overflow: ALU_CTRL=1111 with any operands -> result 0x0000 after 1 cycle. Flags build: ADD 0x7FFF+0x0001 -> 0x8000, overflow=1, carry=0.
